// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, mux selects,
// ALU control codes, op/cond constants and the per-state Moore control vector.
package mc_ctrl_pkg;

    localparam int unsigned FLAGS_W  = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned ALUCTL_W = 3;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned COND_W   = 4;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_UNKNOWN
    } state_t;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_ORR = 3'b011;

    localparam logic [SEL_W-1:0] SRCA_REG = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_PC  = 2'b01;

    localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic             ir_write;
        logic             next_pc;
        logic             reg_w;
        logic             mem_w;
        logic             branch;
        logic             alu_op;
        logic             adr_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] result_src;
    } ctl_t;

    // Moore control vector for a state; anything not set stays 0.
    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.next_pc    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_w      = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_b = SRCB_REG;
                c.alu_op    = 1'b1;
            end
            S_EXECUTEI: begin
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = 1'b1;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALURESULT;
                c.branch     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction field and ALU flags in, enables
// and mux selects out. master = controller side, slave = datapath side.
interface mc_controller_if;
    import mc_ctrl_pkg::*;

    logic [31:12]         Instr;
    logic [FLAGS_W-1:0]   ALUFlags;
    logic                 PCWrite;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 IRWrite;
    logic                 AdrSrc;
    logic [SEL_W-1:0]     RegSrc;
    logic [SEL_W-1:0]     ALUSrcA;
    logic [SEL_W-1:0]     ALUSrcB;
    logic [SEL_W-1:0]     ResultSrc;
    logic [SEL_W-1:0]     ImmSrc;
    logic [ALUCTL_W-1:0]  ALUControl;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );
endinterface

// File: rtl/cond_logic.sv
// NZCV flag register, condition-code evaluation and write-strobe gating for
// the multicycle controller.
module cond_logic
    import mc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] alu_flags,
    input  logic [1:0]         flag_w,
    input  logic               capture,
    input  logic               next_pc,
    input  logic               branch,
    input  logic               reg_w,
    input  logic               mem_w,
    input  logic               rd_is_pc,
    output logic               pc_write,
    output logic               reg_write,
    output logic               mem_write
);

    logic [FLAGS_W-1:0] flags_q;
    logic               condex;
    logic               condex_q;
    logic               n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // condex is frozen at the end of DECODE; flags only move when that instruction executes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q  <= '0;
            condex_q <= 1'b0;
        end else begin
            if (capture)
                condex_q <= condex;
            if (flag_w[1] && condex_q)
                flags_q[3:2] <= alu_flags[3:2];
            if (flag_w[0] && condex_q)
                flags_q[1:0] <= alu_flags[1:0];
        end
    end

    assign reg_write = reset & reg_w & condex_q;
    assign mem_write = reset & mem_w & condex_q;
    assign pc_write  = reset & (next_pc | ((branch | (reg_w & rd_is_pc)) & condex_q));

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: Moore main FSM, ALU decoder and condition unit.
// Optional `MC_CTRL_CMP_EN adds CMP (cmd 1010) as a flag-only SUB that skips ALUWB.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);

    state_t              state_q;
    state_t              state_d;
    ctl_t                ctl_q;
    logic [1:0]          op;
    logic [FUNCT_W-1:0]  funct;
    logic [3:0]          cmd;
    logic [ALUCTL_W-1:0] alu_control;
    logic [1:0]          flag_w;
    logic                no_write;
    logic                unused_rn;

    assign op        = bus.Instr[27:26];
    assign funct     = bus.Instr[25:20];
    assign cmd       = funct[4:1];
    assign unused_rn = ^bus.Instr[19:16];

    // ALU decoder: only active in the execute states.
    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        no_write    = 1'b0;
        if (ctl_q.alu_op) begin
            case (cmd)
                4'b0100: alu_control = ALU_ADD;
                4'b0010: alu_control = ALU_SUB;
                4'b0000: alu_control = ALU_AND;
                4'b1100: alu_control = ALU_ORR;
`ifdef MC_CTRL_CMP_EN
                4'b1010: begin
                    alu_control = ALU_SUB;
                    no_write    = 1'b1;
                end
`endif
                default: alu_control = ALU_ADD;
            endcase
            flag_w[1] = funct[0];
            flag_w[0] = funct[0] & ((alu_control == ALU_ADD) | (alu_control == ALU_SUB));
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI: state_d = no_write ? S_FETCH : S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control vector is registered together with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctl_q   <= state_ctl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctl_q   <= state_ctl(state_d);
        end
    end

    cond_logic u_cond_logic (
        .clk       (clk),
        .reset     (reset),
        .cond      (bus.Instr[31:28]),
        .alu_flags (bus.ALUFlags),
        .flag_w    (flag_w),
        .capture   (state_q == S_DECODE),
        .next_pc   (ctl_q.next_pc),
        .branch    (ctl_q.branch),
        .reg_w     (ctl_q.reg_w),
        .mem_w     (ctl_q.mem_w),
        .rd_is_pc  (bus.Instr[15:12] == 4'hF),
        .pc_write  (bus.PCWrite),
        .reg_write (bus.RegWrite),
        .mem_write (bus.MemWrite)
    );

    assign bus.IRWrite    = reset & ctl_q.ir_write;
    assign bus.AdrSrc     = ctl_q.adr_src;
    assign bus.ALUSrcA    = ctl_q.alu_src_a;
    assign bus.ALUSrcB    = ctl_q.alu_src_b;
    assign bus.ResultSrc  = ctl_q.result_src;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
    assign bus.ALUControl = alu_control;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle ARM datapath.
- Takes the instruction register upper field and the ALU flags.
- Sequences every instruction through a Moore main FSM and decodes ALU operations.
- Holds the NZCV flags and evaluates condition codes.
- Drives every datapath enable and mux select, plus MemWrite to memory.

Parameters:
- None. All encodings are fixed in mc_ctrl_pkg.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- Instr  in  20  Instr[31:12] from the instruction register.
- ALUFlags  in  4  {N,Z,C,V} from the ALU, combinational.
- PCWrite  out  1  PC register enable.
- MemWrite  out  1  memory write enable.
- RegWrite  out  1  register file write enable.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  0=PC, 1=Result.
- RegSrc  out  2  [0]: RA1=R15; [1]: RA2=Rd.
- ALUSrcA  out  2  00=A, 01=PC.
- ALUSrcB  out  2  00=reg (WriteData), 01=ExtImm, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  out  2  equals Instr[27:26].
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR.

Behaviour:
- Fields: op=Instr[27:26], funct=Instr[25:20], Rd=Instr[15:12], cond=Instr[31:28].
- State register, flag register and condex_q all update on rising clk.
- Reset (reset==0 at a clock edge):
  - state=FETCH, flags=0000, condex_q=0.
  - While reset==0, PCWrite/RegWrite/MemWrite/IRWrite are forced 0.
  - Mux selects take their FETCH values.
- States and transitions:
  - FETCH→DECODE.
  - DECODE: op=01→MEMADR; op=00 with funct[5]=0→EXECUTER; op=00 with funct[5]=1→EXECUTEI; op=10→BRANCH; op=11→FETCH (NOP).
  - MEMADR: funct[0]=1→MEMREAD, else→MEMWRITE.
  - MEMREAD→MEMWB→FETCH; MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH; BRANCH→FETCH.
- Unlisted signals are 0 in every state.
- Per-state outputs (Moore; ImmSrc and RegSrc are combinational on Instr):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1, ALUControl=ADD.
- RegSrc[0]=(op==10); RegSrc[1]=(op==01).
- ALU decode (ALUOp=1), cmd=funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - Any other cmd executes as ADD.
  - FlagW[1] (NZ) = funct[0].
  - FlagW[0] (CV) = funct[0] & (ADD|SUB).
  - FlagW=00 when ALUOp=0.
- Condition logic:
  - condex is combinational from cond and the flag register.
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL (1110)=1; cond 1111 yields 0.
  - condex_q captures condex at the end of DECODE only.
- Gating:
  - RegWrite = RegW & condex_q.
  - MemWrite = MemW & condex_q.
  - PCWrite = NextPC | ((Branch | (RegW & Rd==15)) & condex_q).
- Flags: bits written from ALUFlags at the end of EXECUTER/EXECUTEI when the matching FlagW bit=1 and condex_q=1; otherwise held.
- Latency: branch 3 cycles; data-processing 4; STR 4; LDR 5; op=11 takes 2.
- Reset mid-instruction aborts it: no write strobes are issued, and the FSM restarts at FETCH after release.

Optional Feature:
- Macro: MC_CTRL_CMP_EN.
- Defined:
  - cmd 1010 (CMP) decodes as SUB with NoWrite.
  - FlagW per the SUB rule.
  - EXECUTER/EXECUTEI→FETCH, skipping ALUWB, so RegWrite is never asserted.
- Undefined: cmd 1010 falls into the "other cmd" rule (ADD, writes Rd).

Decomposition:
- mc_ctrl_pkg holds:
  - state enum (11 states).
  - ALUControl codes.
  - ALUSrcA, ALUSrcB, ResultSrc select codes.
  - op and cond code constants.
- Sub-module cond_logic owns flag register, condex and condex_q, and the write gating.
- FSM and ALU decoder stay in mc_controller.

Test Plan:
- Reset: hold reset=0 for 3 cycles → IRWrite=0, PCWrite=0. Release → first cycle IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- ADD R1,R2,R3 (0xE0821003) → FETCH, DECODE, EXECUTER (ALUControl=000, ALUSrcB=00), ALUWB (RegWrite=1), FETCH. Total 4 cycles.
- SUBS R0,R0,R0 (0xE0500000) with ALUFlags=0100 → Z=1. Then BEQ 0x0A000002 → PCWrite=1 in BRANCH. Repeat with ALUFlags=0000 → PCWrite=0 in BRANCH.
- LDR 0xE5921004 → MEMREAD with AdrSrc=1, MEMWB with ResultSrc=01 and RegWrite=1. STR 0xE5821004 → RegSrc=10, MemWrite=1 in MEMWRITE only.
- ADDSNE (0x10921003) with Z=1 → RegWrite=0 in ALUWB, flags unchanged. ADD PC,... (Rd=15, AL) → PCWrite=1 in ALUWB.
- reset=0 asserted during MEMREAD → MemWrite/RegWrite stay 0, flags=0000, state=FETCH after release. With MC_CTRL_CMP_EN, CMP (0xE1500001) → 3 cycles, RegWrite never 1.
